// File: rtl/pcie_pkg.sv
// Shared constants and types for the PCIE switch statistics block.
// Counter select codes, read-FSM state encoding and the default counter width.
package pcie_pkg;

  localparam int unsigned CNT_W_DEF = 5;

  localparam logic [2:0] IDX_FIFO4 = 3'd0;
  localparam logic [2:0] IDX_FIFO5 = 3'd1;
  localparam logic [2:0] IDX_FIFO6 = 3'd2;
  localparam logic [2:0] IDX_FIFO7 = 3'd3;
  localparam logic [2:0] IDX_IN    = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  function automatic logic idx_ok(input logic [2:0] idx);
    return idx <= IDX_IN;
  endfunction

endpackage

// File: rtl/pcie_contador.sv
// Single wrap-around event counter with synchronous clear and async active-low reset.
// A clear coinciding with an increment leaves 1 so the event is not lost.
module pcie_contador
  import pcie_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? CNT_W'(1) : '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pcie_contadores.sv
// Passive push/pop statistics for the PCIE switch with a req/idx streaming read port.
// Define PCIE_CONTADORES_CLEAR_ON_READ_EN to make valid reads clear the selected counter.
module pcie_contadores
  import pcie_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned N_OUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_in,
  input  logic             full_in,
  input  logic [N_OUT-1:0] pop_out,
  input  logic [N_OUT-1:0] empty_out,
  input  logic             active,
  input  logic             req,
  input  logic [2:0]       idx,
  output logic [CNT_W-1:0] data_cnt,
  output logic             valid,
  output logic             idx_err
);

  // Reset asserts asynchronously but releases two edges later.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  logic [N_OUT:0]   w_inc;
  logic [N_OUT:0]   w_clr;
  logic [CNT_W-1:0] w_cnt [N_OUT+1];

  assign w_inc[N_OUT]     = push_in & ~full_in & active;
  assign w_inc[N_OUT-1:0] = pop_out & ~empty_out & {N_OUT{active}};

`ifdef PCIE_CONTADORES_CLEAR_ON_READ_EN
  always_comb begin
    w_clr = '0;
    for (int i = 0; i <= int'(N_OUT); i++) begin
      w_clr[i] = req && (idx == 3'(i));
    end
  end
`else
  assign w_clr = '0;
`endif

  for (genvar g = 0; g <= int'(N_OUT); g++) begin : g_cnt
    pcie_contador #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .i_clk  (clk),
      .i_rst_n(w_rst_n),
      .i_inc  (w_inc[g]),
      .i_clr  (w_clr[g]),
      .o_cnt  (w_cnt[g])
    );
  end

  logic [CNT_W-1:0] w_sel;
  logic             w_sel_err;

  always_comb begin
    w_sel     = '0;
    w_sel_err = !idx_ok(idx);
    case (idx)
      IDX_FIFO4: w_sel = w_cnt[0];
      IDX_FIFO5: w_sel = w_cnt[1];
      IDX_FIFO6: w_sel = w_cnt[2];
      IDX_FIFO7: w_sel = w_cnt[3];
      IDX_IN:    w_sel = w_cnt[4];
      default:   w_sel = '0;
    endcase
  end

  rd_state_e        r_state;
  rd_state_e        w_state_d;
  logic [CNT_W-1:0] r_data;
  logic             r_err;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (req) begin
        r_data <= w_sel;
        r_err  <= w_sel_err;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    w_state_d = req ? READ : IDLE;
      READ:    w_state_d = req ? READ : IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    valid    = (r_state == READ);
    idx_err  = (r_state == READ) && r_err;
    data_cnt = r_data;
  end

endmodule

// File: tb/tb_pcie_contadores.sv
// Self-checking bench for pcie_contadores: vector table plus hand-written corner sequences.
// Expected outputs are queued when stimulus is driven and compared after the clock edge.
module tb_pcie_contadores;

`ifdef PCIE_CONTADORES_CLEAR_ON_READ_EN
  localparam bit COR = 1'b1;
`else
  localparam bit COR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push_in = 1'b0;
  logic       full_in = 1'b0;
  logic [3:0] pop_out = '0;
  logic [3:0] empty_out = '0;
  logic       active = 1'b0;
  logic       req = 1'b0;
  logic [2:0] idx = '0;
  logic [4:0] data_cnt;
  logic       valid;
  logic       idx_err;

  always #5 clk = ~clk;

  pcie_contadores #(
    .CNT_W(5),
    .N_OUT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push_in  (push_in),
    .full_in  (full_in),
    .pop_out  (pop_out),
    .empty_out(empty_out),
    .active   (active),
    .req      (req),
    .idx      (idx),
    .data_cnt (data_cnt),
    .valid    (valid),
    .idx_err  (idx_err)
  );

  typedef struct {
    logic       push;
    logic       full;
    logic [3:0] pop;
    logic [3:0] empty;
    logic       act;
    logic       rq;
    logic [2:0] ix;
    logic       chk;
    logic [4:0] data;
    logic       v;
    logic       e;
  } vec_t;

  typedef struct {
    logic       chk;
    logic [4:0] data;
    logic       v;
    logic       e;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  vec_t  tbl[$];
  int    n_checks = 0;
  int    n_fail = 0;

  function automatic vec_t mk(logic push, logic full, logic [3:0] pop, logic [3:0] empty,
                              logic act, logic rq, logic [2:0] ix, logic chk,
                              logic [4:0] d, logic v, logic e);
    vec_t r;
    r.push = push; r.full = full; r.pop = pop; r.empty = empty; r.act = act;
    r.rq = rq; r.ix = ix; r.chk = chk; r.data = d; r.v = v; r.e = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [4:0] ed, input logic ev, input logic ee);
    n_checks++;
    if (data_cnt !== ed || valid !== ev || idx_err !== ee) begin
      n_fail++;
      $display("FAIL %s: got data_cnt=%0d valid=%b idx_err=%b, want data_cnt=%0d valid=%b idx_err=%b",
               name, data_cnt, valid, idx_err, ed, ev, ee);
    end
  endtask

  task automatic step(input vec_t s, input string name);
    exp_t x;
    string n;
    @(negedge clk);
    push_in = s.push; full_in = s.full; pop_out = s.pop; empty_out = s.empty;
    active = s.act; req = s.rq; idx = s.ix;
    sb.push_back('{chk: s.chk, data: s.data, v: s.v, e: s.e});
    sb_name.push_back(name);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    n = sb_name.pop_front();
    if (x.chk) check(n, x.data, x.v, x.e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(0, 0, 4'h0, 4'h0, 1, 0, 3'd0, 0, 0, 0, 0), "idle");
  endtask

  task automatic pushes(input int n, input logic full, input logic act);
    for (int i = 0; i < n; i++) step(mk(1, full, 4'h0, 4'h0, act, 0, 3'd0, 0, 0, 0, 0), "push");
  endtask

  task automatic rd(input logic [2:0] ix, input logic [4:0] d, input logic e, input string name);
    step(mk(0, 0, 4'h0, 4'h0, 1, 1, ix, 1, d, 1, e), name);
  endtask

  task automatic rd_end(input logic [4:0] d, input string name);
    step(mk(0, 0, 4'h0, 4'h0, 1, 0, 3'd0, 1, d, 0, 0), name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; push_in = 0; full_in = 0; pop_out = '0; empty_out = '0;
    active = 0; req = 0; idx = '0;
    #1;
    check("reset_outputs", 5'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Per-FIFO pop table, applied right after a reset (data_cnt holds 0 until the first read).
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 1, 0, 3'd0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b0000, 1, 0, 3'd0, 1, 0, 0, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 4'b0100, 4'b0000, 1, 0, 3'd0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 4'b1000, 4'b1000, 1, 0, 3'd0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 1, 3'd0, 1, 3, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 1, 3'd1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 1, 3'd2, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 1, 3'd3, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 3'd0, 1, 0, 0, 0));

    // Reset and idle reads of every counter
    do_reset();
    for (int i = 0; i < 5; i++) rd(3'(i), 5'd0, 1'b0, $sformatf("reset_rd_idx%0d", i));
    rd_end(5'd0, "reset_rd_end");

    // Input push counting, full pushes ignored
    pushes(7, 1'b0, 1'b1);
    pushes(2, 1'b1, 1'b1);
    rd(3'd4, 5'd7, 1'b0, "in_cnt");
    rd_end(5'd7, "in_cnt_end");

    // Per-FIFO pop counting
    do_reset();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl[%0d]", i));

    // Wrap-around and freeze
    do_reset();
    pushes(33, 1'b0, 1'b1);
    rd(3'd4, 5'd1, 1'b0, "wrap");
    rd_end(5'd1, "wrap_end");
    pushes(3, 1'b0, 1'b0);
    rd(3'd4, COR ? 5'd0 : 5'd1, 1'b0, "freeze");
    rd_end(COR ? 5'd0 : 5'd1, "freeze_end");

    // Read coinciding with a counted pop, then invalid selects
    do_reset();
    for (int i = 0; i < 5; i++) step(mk(0, 0, 4'b0001, 4'b0000, 1, 0, 3'd0, 0, 0, 0, 0), "pop");
    step(mk(0, 0, 4'b0001, 4'b0000, 1, 1, 3'd0, 1, 5, 1, 0), "rd_same_cycle_inc");
    rd(3'd0, COR ? 5'd1 : 5'd6, 1'b0, "rd_after_inc");
    rd(3'd6, 5'd0, 1'b1, "idx6_invalid");
    rd(3'd7, 5'd0, 1'b1, "idx7_invalid");
    rd_end(5'd0, "invalid_end");

    // Reset dropped mid-stream, between clock edges
    do_reset();
    pushes(3, 1'b0, 1'b1);
    rd(3'd4, 5'd3, 1'b0, "stream_rd0");
    rd(3'd4, COR ? 5'd0 : 5'd3, 1'b0, "stream_rd1");
    #3;
    reset = 1'b0;
    #1;
    check("mid_read_reset", 5'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(3);
    for (int i = 0; i < 5; i++) rd(3'(i), 5'd0, 1'b0, $sformatf("post_reset_idx%0d", i));
    rd_end(5'd0, "post_reset_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
